imem_loader: RTL and testbench

- Boot-time writer for the processor's word-addressed instruction memory (capacity words of WIDTH bits, indexed by word number).
- Consumes a byte stream, typically from a UART receiver, with valid/ready handshake; assembles little-endian words; issues one write per word.
- Holds the CPU in reset until a complete, checksum-verified image is written.
- Replaces the build-time hex preload when firmware is delivered at run time.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_word_packer.sv | 50 +++++
 rtl/imem_loader.sv | 122 ++++++++++++
 tb/tb_imem_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int unsigned IMEM_CAPACITY  = 128;
  localparam int unsigned IMEM_WIDTH     = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned CSUM_BYTES     = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles little-endian byte handshakes into words and pulses word_valid
// one cycle after the last lane; word holds its value between pulses.
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int unsigned WIDTH = IMEM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             byte_fire,
  input  logic [7:0]       byte_data,
  output logic             lane_last_c,
  output logic [WIDTH-1:0] word,
  output logic             word_valid
);

  localparam int unsigned LANE_W = $clog2(BYTES_PER_WORD);

  logic [LANE_W-1:0] lane;
  logic [WIDTH-9:0]  shreg;

  assign lane_last_c = (lane == LANE_W'(BYTES_PER_WORD - 1));

  // Lower lanes accumulate in shreg; the last lane completes the word in one step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane       <= '0;
      shreg      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        lane  <= '0;
        shreg <= '0;
      end else if (byte_fire) begin
        if (lane_last_c) begin
          word       <= {byte_data, shreg};
          word_valid <= 1'b1;
          lane       <= '0;
        end else begin
          shreg <= {byte_data, shreg[WIDTH-9:8]};
          lane  <= lane + LANE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: receives a length-prefixed, XOR-checksummed byte image,
// writes it word by word into instruction memory and releases the CPU on success.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned CAPACITY = IMEM_CAPACITY,
  parameter int unsigned WIDTH    = IMEM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             cpu_rst_n,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(CAPACITY) + 1;

  state_t           state;
  state_t           nxt;
  logic [7:0]       len_lo;
  logic [15:0]      len;
  logic [7:0]       csum;
  logic [CNT_W-1:0] wcnt;

  logic        hs_c;
  logic        clr_c;
  logic        lane_last_c;
  logic        last_word_c;
  logic [15:0] n_c;

  assign hs_c        = byte_valid && byte_ready;
  assign clr_c       = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign n_c         = {byte_data, len_lo};
  assign last_word_c = ((16'(wcnt) + 16'd1) == len);

  imem_word_packer #(.WIDTH(WIDTH)) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr_c),
    .byte_fire   (hs_c && state == ST_DATA),
    .byte_data   (byte_data),
    .lane_last_c (lane_last_c),
    .word        (mem_wdata),
    .word_valid  (mem_we)
  );

  // Next-state decode.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (start) nxt = ST_LEN0;
      ST_LEN0: if (hs_c) nxt = ST_LEN1;
      ST_LEN1: begin
        if (hs_c) begin
          if (n_c > 16'(CAPACITY)) nxt = ST_ERR;
          else if (n_c == 16'd0)   nxt = ST_CSUM;
          else                     nxt = ST_DATA;
        end
      end
      ST_DATA: if (hs_c && lane_last_c && last_word_c) nxt = ST_CSUM;
      ST_CSUM: if (hs_c) nxt = (byte_data == csum) ? ST_DONE : ST_ERR;
      ST_DONE: if (start) nxt = ST_LEN0;
      ST_ERR:  if (start) nxt = ST_LEN0;
      default: nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered decodes of the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_rst_n  <= 1'b0;
    end else begin
      state      <= nxt;
      byte_ready <= (nxt == ST_LEN0 || nxt == ST_LEN1 || nxt == ST_DATA || nxt == ST_CSUM);
      busy       <= (nxt == ST_LEN0 || nxt == ST_LEN1 || nxt == ST_DATA || nxt == ST_CSUM);
      done       <= (nxt == ST_DONE);
      err        <= (nxt == ST_ERR);
      cpu_rst_n  <= (nxt == ST_DONE);
    end
  end

  // Header, checksum and word-address bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo   <= '0;
      len      <= '0;
      csum     <= '0;
      wcnt     <= '0;
      mem_addr <= '0;
    end else if (clr_c) begin
      csum <= '0;
      wcnt <= '0;
    end else if (hs_c) begin
      case (state)
        ST_LEN0: len_lo <= byte_data;
        ST_LEN1: len    <= n_c;
        ST_DATA: begin
          csum <= csum ^ byte_data;
          if (lane_last_c) begin
            mem_addr <= WIDTH'(wcnt);
            wcnt     <= wcnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad images, length limits, gaps, mid-load reset.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;
  int wr_n = 0;
  logic prev_we = 1'b0;
  logic [31:0] img [0:127];

  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Count writes and flag back-to-back strobes.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_n++;
      checks++;
      if (prev_we) begin
        errors++;
        $display("FAIL we_back_to_back: mem_we high two cycles running at addr %0d", mem_addr);
      end
    end
    prev_we = mem_we;
  end

  function automatic logic [7:0] calc_csum(input int n);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < n; i++) c = c ^ img[i][7:0] ^ img[i][15:8] ^ img[i][23:16] ^ img[i][31:24];
    return c;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wr_n = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int n;
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    byte_data = b;
    byte_valid = 1'b1;
    n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (byte_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte_ready=%b after %0d cycles, need 1", byte_ready, n);
    end
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_image(input int n, input logic [7:0] cs, input int maxgap);
    logic [15:0] len;
    len = 16'(n);
    for (int h = 0; h < int'(LEN_BYTES); h++) send_byte(len[8*h +: 8], maxgap);
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < int'(BYTES_PER_WORD); b++) send_byte(img[w][8*b +: 8], maxgap);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 32'(w) || mem_wdata !== img[w]) begin
        errors++;
        $display("FAIL word_write[%0d]: we=%b addr=%0d data=%h, need we=1 addr=%0d data=%h",
                 w, mem_we, mem_addr, mem_wdata, w, img[w]);
      end
    end
    send_byte(cs, maxgap);
  endtask

  task automatic check_end(input string name, input logic exp_done, input int exp_wr);
    checks++;
    if (done !== exp_done || err !== !exp_done || cpu_rst_n !== exp_done || busy !== 1'b0 ||
        byte_ready !== 1'b0 || wr_n !== exp_wr) begin
      errors++;
      $display("FAIL %s: done=%b err=%b cpu_rst_n=%b busy=%b ready=%b writes=%0d, need done=%b err=%b cpu_rst_n=%b busy=0 ready=0 writes=%0d",
               name, done, err, cpu_rst_n, busy, byte_ready, wr_n, exp_done, !exp_done, exp_done, exp_wr);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (byte_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        cpu_rst_n !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b we=%b addr=%h data=%h cpu_rst_n=%b busy=%b done=%b err=%b, need all 0",
               byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err);
    end
  endtask

  task automatic test_basic();
    do_reset();
    img[0] = 32'h12345678;
    img[1] = 32'hDEADBEEF;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_busy: busy=%b ready=%b, need 1 1", busy, byte_ready);
    end
    send_image(2, 8'h2A, 0);
    check_end("basic_done", 1'b1, 2);
  endtask

  task automatic test_bad_csum();
    do_reset();
    pulse_start();
    send_image(2, 8'h00, 0);
    check_end("bad_csum_err", 1'b0, 2);
    pulse_start();
    checks++;
    if (busy !== 1'b1 || err !== 1'b0 || byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL err_restart: busy=%b err=%b ready=%b, need 1 0 1", busy, err, byte_ready);
    end
  endtask

  task automatic test_capacity();
    do_reset();
    pulse_start();
    send_byte(8'h81, 0);
    send_byte(8'h00, 0);
    check_end("oversize_err", 1'b0, 0);
    for (int i = 0; i < 128; i++) img[i] = {8'(i), 8'(~i), 8'(i * 3), 8'hA5};
    wr_n = 0;
    pulse_start();
    send_image(128, calc_csum(128), 0);
    check_end("full_done", 1'b1, 128);
    checks++;
    if (mem_addr !== 32'd127) begin
      errors++;
      $display("FAIL full_last_addr: addr=%0d, need 127", mem_addr);
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    pulse_start();
    send_image(0, 8'h00, 0);
    check_end("zero_done", 1'b1, 0);
    pulse_start();
    checks++;
    if (cpu_rst_n !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL done_restart: cpu_rst_n=%b busy=%b done=%b, need 0 1 0", cpu_rst_n, busy, done);
    end
    send_image(0, 8'h01, 0);
    check_end("zero_bad_err", 1'b0, 0);
  endtask

  task automatic test_gaps();
    do_reset();
    img[0] = 32'h12345678;
    img[1] = 32'hDEADBEEF;
    pulse_start();
    send_image(2, 8'h2A, 7);
    check_end("gaps_done", 1'b1, 2);
    byte_data = 8'h55;
    byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (byte_ready !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_idle[%0d]: ready=%b done=%b busy=%b, need 0 1 0", i, byte_ready, done, busy);
      end
    end
    byte_valid = 1'b0;
    checks++;
    if (wr_n !== 2) begin
      errors++;
      $display("FAIL done_no_write: writes=%0d, need 2", wr_n);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    img[0] = 32'h12345678;
    img[1] = 32'hDEADBEEF;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int b = 0; b < 5; b++) send_byte(8'(8'h10 + b), 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (byte_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        cpu_rst_n !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ready=%b we=%b addr=%h data=%h cpu_rst_n=%b busy=%b done=%b err=%b, need all 0",
               byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    wr_n = 0;
    pulse_start();
    send_image(2, 8'h2A, 0);
    check_end("reload_done", 1'b1, 2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_capacity();
    test_zero_len();
    test_gaps();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
